// File: rtl/memsync_xfer_ctrl.sv
// Row-copy sequencer for the MEMSync WriteBack/Allocate states: issues one column command per
// column of a row over valid/ready, tracks completions, and pulses sync once the row has settled.
module memsync_xfer_ctrl #(
  parameter int CHWIDTH   = 6,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 5,
  parameter int MAXOUT    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_req,
  input  logic                 al_req,
  input  logic [CHWIDTH-1:0]   req_crow,
  input  logic [ADDRWIDTH-1:0] wb_row,
  input  logic [ADDRWIDTH-1:0] al_row,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_dir,
  output logic [ADDRWIDTH-1:0] cmd_row,
  output logic [CHWIDTH-1:0]   cmd_crow,
  output logic [COLWIDTH-1:0]  cmd_col,
  input  logic                 cpl_valid,
  output logic                 sync,
  output logic                 busy,
  output logic [1:0]           err
);

  localparam int OW = $clog2(MAXOUT + 1);
  localparam logic [OW-1:0] MAXOUT_C = OW'(MAXOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_DRAIN = 3'd2,
    S_SYNC  = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   dir_q, dir_d;
  logic [CHWIDTH-1:0]     crow_q, crow_d;
  logic [ADDRWIDTH-1:0]   row_q, row_d;
  logic [COLWIDTH-1:0]    col_q, col_d;
  logic [OW-1:0]          outst_q, outst_d;
  logic                   aborted_q, aborted_d;
  logic [1:0]             err_q, err_d;

  logic accept;
  logic cpl_ok;
  logic req_active;
  logic start_dir;

  assign cmd_valid  = (state_q == S_ISSUE) && (outst_q < MAXOUT_C);
  assign accept     = cmd_valid & cmd_ready;
  assign cpl_ok     = cpl_valid && (outst_q != '0);
  assign req_active = dir_q ? al_req : wb_req;
  assign start_dir  = al_req & ~wb_req;

  assign cmd_dir  = dir_q;
  assign cmd_row  = row_q;
  assign cmd_crow = crow_q;
  assign cmd_col  = col_q;
  assign sync     = (state_q == S_SYNC);
  assign busy     = (state_q != S_IDLE);
  assign err      = err_q;

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    crow_d    = crow_q;
    row_d     = row_q;
    col_d     = col_q;
    aborted_d = aborted_q;
    err_d     = err_q;
    outst_d   = outst_q;

    // A completion with nothing outstanding is dropped and flagged rather than underflowing.
    case ({accept, cpl_ok})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    if (cpl_valid && (outst_q == '0)) begin
      err_d[0] = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (wb_req || al_req) begin
          dir_d     = start_dir;
          crow_d    = req_crow;
          row_d     = start_dir ? al_row : wb_row;
          col_d     = '0;
          aborted_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          col_d = col_q + COLWIDTH'(1);
        end
        if (!req_active) begin
          aborted_d = 1'b1;
          err_d[1]  = 1'b1;
          state_d   = S_DRAIN;
        end else if (accept && (&col_q)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // An aborted copy still waits for its in-flight completions, but leaves without sync.
        if (!aborted_q && !req_active) begin
          aborted_d = 1'b1;
          err_d[1]  = 1'b1;
        end
        if (outst_q == '0) begin
          state_d = (aborted_q || !req_active) ? S_IDLE : S_SYNC;
        end
      end
      S_SYNC:  state_d = S_HOLD;
      S_HOLD:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      dir_q     <= 1'b0;
      crow_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      outst_q   <= '0;
      aborted_q <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      crow_q    <= crow_d;
      row_q     <= row_d;
      col_q     <= col_d;
      outst_q   <= outst_d;
      aborted_q <= aborted_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_memsync_xfer_ctrl.sv
// Self-checking bench for memsync_xfer_ctrl: per-scenario tasks checked against a transaction-level
// model that counts accepted/completed commands and derives valid, sync and busy timing from them.
module tb_memsync_xfer_ctrl;

  localparam int CHW  = 6;
  localparam int AW   = 17;
  localparam int CW   = 2;
  localparam int MO   = 4;
  localparam int NCOL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_req, al_req;
  logic [CHW-1:0] req_crow;
  logic [AW-1:0] wb_row, al_row;
  logic          cmd_valid, cmd_ready, cmd_dir;
  logic [AW-1:0] cmd_row;
  logic [CHW-1:0] cmd_crow;
  logic [CW-1:0] cmd_col;
  logic          cpl_valid, sync, busy;
  logic [1:0]    err;

  int n_vec = 0;
  int n_bad = 0;

  memsync_xfer_ctrl #(.CHWIDTH(CHW), .ADDRWIDTH(AW), .COLWIDTH(CW), .MAXOUT(MO)) dut (
    .clk(clk), .rst(rst), .wb_req(wb_req), .al_req(al_req), .req_crow(req_crow),
    .wb_row(wb_row), .al_row(al_row), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_row(cmd_row), .cmd_crow(cmd_crow), .cmd_col(cmd_col),
    .cpl_valid(cpl_valid), .sync(sync), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b0; wb_req = 1'b1; al_req = 1'b0; cmd_ready = 1'b0; cpl_valid = 1'b0;
    req_crow = '0; wb_row = '0; al_row = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_vec++;
      if ({cmd_valid, sync, busy, err} !== 5'b0) begin
        n_bad++;
        $display("FAIL reset_hold: valid/sync/busy/err=%b required 00000", {cmd_valid, sync, busy, err});
      end
    end
    rst = 1'b1; wb_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: busy=%b valid=%b required 0 0", busy, cmd_valid);
    end
  endtask

  // One complete transfer; cycle 0 is the IDLE cycle in which the request is presented.
  // ready_mode: 0 always ready, 1 toggling, 2 random. Ends after driving the HOLD cycle.
  task automatic run_xfer(input string name, input logic dir, input logic [AW-1:0] row,
                          input logic [CHW-1:0] crow, input int ready_mode, input bit hold_cpl,
                          input int max_dly, input bit next_al);
    int acc, ncpl, last_cpl, c;
    int due[$];
    bit done, finished;
    logic exp_v, exp_s, exp_b, rdy, cv;
    acc = 0; ncpl = 0; last_cpl = 0; done = 0; finished = 0; c = 0;
    while (c < 200 && !finished) begin
      @(negedge clk);
      exp_v = (c >= 1) && (acc < NCOL) && ((acc - ncpl) < MO);
      exp_s = done && (c == last_cpl + 2);
      exp_b = (c >= 1);
      n_vec++;
      if (cmd_valid !== exp_v || sync !== exp_s || busy !== exp_b || err !== 2'b00) begin
        n_bad++;
        $display("FAIL %s_ctl c=%0d: valid/sync/busy/err=%b%b%b%b required %b%b%b00",
                 name, c, cmd_valid, sync, busy, err, exp_v, exp_s, exp_b);
      end
      if (exp_v) begin
        n_vec++;
        if (cmd_col !== CW'(acc) || cmd_dir !== dir || cmd_row !== row || cmd_crow !== crow) begin
          n_bad++;
          $display("FAIL %s_cmd c=%0d: col=%0d dir=%b row=%h crow=%0d required col=%0d dir=%b row=%h crow=%0d",
                   name, c, cmd_col, cmd_dir, cmd_row, cmd_crow, acc, dir, row, crow);
        end
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = (c % 2) == 1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      cv = 1'b0;
      if (due.size() > 0 && due[0] <= c && !(hold_cpl && acc < NCOL)) begin
        cv = 1'b1;
        void'(due.pop_front());
      end
      if (c == 0) begin
        wb_req = ~dir; al_req = dir; req_crow = crow;
        if (dir) al_row = row; else wb_row = row;
      end
      cmd_ready = rdy;
      cpl_valid = cv;
      if (cv) begin
        ncpl++;
        if (ncpl == NCOL) begin
          done = 1;
          last_cpl = c;
        end
      end
      if (exp_v && rdy) begin
        due.push_back(c + int'($urandom_range(1, max_dly)));
        acc++;
      end
      if (done && c == last_cpl + 3) begin
        wb_req = 1'b0; al_req = next_al; cmd_ready = 1'b0;
        finished = 1;
      end
      c++;
    end
    if (!finished) begin
      n_vec++; n_bad++;
      $display("FAIL %s_timeout: transfer did not finish, accepted=%0d completed=%0d required %0d", name, acc, ncpl, NCOL);
    end
  endtask

  task automatic test_writeback();
    run_xfer("wb", 1'b0, 17'h1ABCD, 6'd5, 0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_alloc_backpressure();
    run_xfer("al_bp", 1'b1, 17'h00042, 6'd9, 1, 1'b1, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_xfer("b2b_wb", 1'b0, 17'h0F00F, 6'd33, 0, 1'b0, 2, 1'b1);
    run_xfer("b2b_al", 1'b1, 17'h10203, 6'd33, 2, 1'b0, 3, 1'b0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      run_xfer("rand", 1'($urandom_range(0, 1)), AW'($urandom), CHW'($urandom), 2,
               1'($urandom_range(0, 1)), int'($urandom_range(1, 4)), 1'b0);
    end
  endtask

  task automatic test_abort();
    logic exp_v, exp_b;
    logic [1:0] exp_e;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      exp_v = (c >= 1 && c <= 3);
      exp_b = (c >= 1 && c <= 6);
      exp_e = (c >= 4) ? 2'b10 : 2'b00;
      n_vec++;
      if (cmd_valid !== exp_v || busy !== exp_b || sync !== 1'b0 || err !== exp_e) begin
        n_bad++;
        $display("FAIL abort c=%0d: valid/busy/sync/err=%b%b%b%b required %b%b0%b",
                 c, cmd_valid, busy, sync, err, exp_v, exp_b, exp_e);
      end
      if (c == 0) begin
        al_req = 1'b1; wb_req = 1'b0; al_row = 17'h15555; req_crow = 6'd2;
      end
      cmd_ready = (c == 1 || c == 2);
      if (c == 3) al_req = 1'b0;
      cpl_valid = (c == 4 || c == 5);
    end
  endtask

  task automatic test_errors_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b1;
    @(negedge clk);
    cpl_valid = 1'b0;
    n_vec++;
    if (err !== 2'b01 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stray_cpl: err=%b busy=%b valid=%b required 01 0 0", err, busy, cmd_valid);
    end
    wb_req = 1'b1; wb_row = 17'h0A5A5; req_crow = 6'd17; cmd_ready = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_vec++;
      if (cmd_valid !== 1'b1 || cmd_col !== CW'(c - 1)) begin
        n_bad++;
        $display("FAIL no_underflow c=%0d: valid=%b col=%0d required 1 %0d", c, cmd_valid, cmd_col, c - 1);
      end
    end
    @(negedge clk);
    rst = 1'b0; cmd_ready = 1'b0; wb_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({cmd_valid, cmd_dir, cmd_row, cmd_crow, cmd_col, sync, busy, err} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: valid=%b dir=%b row=%h crow=%0d col=%0d sync=%b busy=%b err=%b required all 0",
               cmd_valid, cmd_dir, cmd_row, cmd_crow, cmd_col, sync, busy, err);
    end
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_idle: busy=%b valid=%b required 0 0", busy, cmd_valid);
    end
  endtask

  initial begin
    test_reset();
    test_writeback();
    test_alloc_backpressure();
    test_back_to_back();
    test_random();
    test_abort();
    test_errors_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
